// File: rtl/clockbox_btn_pkg.sv
// clockbox_btn_pkg
//   Shared definitions for the clockbox push-button front end: the per-button
//   conditioning FSM states and the bit positions of each button on btn_raw.
package clockbox_btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int BTN_MODE  = 0;
  localparam int BTN_POWER = 1;
  localparam int BTN_STOP  = 2;
  localparam int BTN_START = 3;

endpackage

// File: rtl/clockbox_button_debounce.sv
// clockbox_button_debounce
//   One push-button channel: 2-flop synchroniser, debounce FSM, hold counter
//   for the long-press event and (optionally) an auto-repeat generator.
//   Optional feature macro: AUTOREPEAT_EN (without it o_repeat is tied 0 and
//   no repeat counter exists).
// Ports
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset (deassertion already synchronous)
//   i_raw      raw active-high pin level, asynchronous to i_clk
//   o_level    debounced level, 1 = held
//   o_press    1-cycle pulse on committed press
//   o_release  1-cycle pulse on committed release
//   o_long     1-cycle pulse when the hold reaches LONG_CYC-1 cycles past commit
//   o_repeat   1-cycle auto-repeat pulses
module clockbox_button_debounce
  import clockbox_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 200,
  parameter int LONG_CYC      = 20000,
  parameter int REPEAT_DELAY  = 5000,
  parameter int REPEAT_PERIOD = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC - 1);

  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("clockbox_button_debounce: all cycle counts must be >= 1");
  end

  logic [1:0]        r_sync;
  logic              w_sync;
  btn_state_t        r_state, w_state_nxt;
  logic [DB_W-1:0]   r_db_cnt, w_db_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_level, w_level_nxt;
  logic              r_press, w_press_nxt;
  logic              r_release, w_release_nxt;
  logic              w_active;

  assign w_sync   = r_sync[1];
  assign w_active = (r_state == HELD) || (r_state == RELEASE_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_state    <= IDLE;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_raw};
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_level    <= w_level_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_db_cnt_nxt   = r_db_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_level_nxt    = r_level;
    w_press_nxt    = 1'b0;
    w_release_nxt  = 1'b0;
    // hold time keeps running through a pending release so a bounce on the
    // way up does not restart the long-press timer
    if (w_active && r_hold_cnt != HOLD_SAT)
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
    case (r_state)
      IDLE: begin
        w_db_cnt_nxt   = '0;
        w_hold_cnt_nxt = '0;
        if (w_sync) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt  = IDLE;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt    = HELD;
          w_db_cnt_nxt   = '0;
          w_hold_cnt_nxt = '0;
          w_press_nxt    = 1'b1;
          w_level_nxt    = 1'b1;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_sync) begin
          w_state_nxt  = RELEASE_WAIT;
          w_db_cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_sync) begin
          w_state_nxt  = HELD;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt    = IDLE;
          w_db_cnt_nxt   = '0;
          w_hold_cnt_nxt = '0;
          w_release_nxt  = 1'b1;
          w_level_nxt    = 1'b0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // hold_cnt saturates one past LONG_CYC-1, so this matches for exactly one
  // cycle per press
  assign o_long    = w_active && (r_hold_cnt == HOLD_LONG);
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_M1  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_M1 = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_armed;   // first pulse already issued this press
  logic             w_rpt_hit;

  assign w_rpt_hit = w_active &&
                     (r_rpt_cnt == (r_rpt_armed ? RPT_PERIOD_M1 : RPT_DELAY_M1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (!w_active) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_hit) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + 1'b1;
    end
  end

  assign o_repeat = w_rpt_hit;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/clockbox_button_frontend.sv
// clockbox_button_frontend
//   Input conditioner for the clockbox buttons (bit0 mode, bit1 power,
//   bit2 stop, bit3 start). Each bit gets its own independent debounce
//   channel; outputs are the per-bit concatenation of the channels.
//   Optional feature macro: AUTOREPEAT_EN enables btn_repeat pulses.
//   reset_L is expected to be deasserted synchronously to clock upstream.
// Ports
//   clock        system clock (10 kHz)
//   reset_L      asynchronous active-low reset
//   btn_raw      raw active-high pin levels
//   btn_level    debounced levels
//   btn_press    1-cycle press pulses
//   btn_release  1-cycle release pulses
//   btn_long     1-cycle long-press pulses
//   btn_repeat   1-cycle auto-repeat pulses (0 without AUTOREPEAT_EN)
module clockbox_button_frontend #(
  parameter int N_BTN         = 4,
  parameter int DEBOUNCE_CYC  = 200,
  parameter int LONG_CYC      = 20000,
  parameter int REPEAT_DELAY  = 5000,
  parameter int REPEAT_PERIOD = 1000
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    clockbox_button_debounce #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .LONG_CYC      (LONG_CYC),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_btn (
      .i_clk     (clock),
      .i_rst_n   (reset_L),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_clockbox_button_frontend.sv
module tb_clockbox_button_frontend;
  import clockbox_btn_pkg::*;

  logic       clock = 1'b0;
  logic       reset_L;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  clockbox_button_frontend dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // per-run event log; cycle 0 = first posedge after the stimulus change
  int         cyc = 0, base = 0;
  int         p_cnt[4], p_cyc[4], r_cnt[4], r_cyc[4], l_cnt[4], l_cyc[4], rp_cnt[4];
  int         rp_cyc[4][8];
  int         first_press_t, both_cnt;
  logic [3:0] first_press_vec, lvl_seen;

  task automatic clear_stats();
    base = cyc;
    for (int b = 0; b < 4; b++) begin
      p_cnt[b] = 0; p_cyc[b] = -1; r_cnt[b] = 0; r_cyc[b] = -1;
      l_cnt[b] = 0; l_cyc[b] = -1; rp_cnt[b] = 0;
      for (int k = 0; k < 8; k++) rp_cyc[b][k] = -1;
    end
    first_press_t = -1; first_press_vec = '0; lvl_seen = '0; both_cnt = 0;
  endtask

  task automatic run(input int n);
    int t;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      t = cyc - base;
      for (int b = 0; b < 4; b++) begin
        if (btn_press[b])   begin if (p_cnt[b] == 0) p_cyc[b] = t; p_cnt[b]++; end
        if (btn_release[b]) begin if (r_cnt[b] == 0) r_cyc[b] = t; r_cnt[b]++; end
        if (btn_long[b])    begin if (l_cnt[b] == 0) l_cyc[b] = t; l_cnt[b]++; end
        if (btn_repeat[b])  begin if (rp_cnt[b] < 8) rp_cyc[b][rp_cnt[b]] = t; rp_cnt[b]++; end
        if (btn_press[b] && btn_release[b]) both_cnt++;
      end
      if (btn_press != 4'h0 && first_press_t < 0) begin
        first_press_t   = t;
        first_press_vec = btn_press;
      end
      lvl_seen |= btn_level;
      cyc++;
    end
  endtask

  initial begin
    // 1: reset with all buttons down, then release reset
    btn_raw = 4'hF;
    reset_L = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_outputs", {12'h0, btn_level, btn_press, btn_release, btn_long, btn_repeat}, 32'h0);
    clear_stats();
    reset_L = 1'b1;
    run(400);
    chk("t1_press_cyc", first_press_t, 202);
    chk("t1_press_vec", first_press_vec, 4'hF);
    chk("t1_press_cnt", p_cnt[0] + p_cnt[1] + p_cnt[2] + p_cnt[3], 4);
    chk("t1_level", btn_level, 4'hF);
    clear_stats();
    btn_raw = 4'h0;
    run(400);
    chk("t1_rel_cyc0", r_cyc[0], 202);
    chk("t1_rel_cyc3", r_cyc[3], 202);
    chk("t1_rel_cnt", r_cnt[0] + r_cnt[1] + r_cnt[2] + r_cnt[3], 4);
    chk("t1_level_off", btn_level, 4'h0);

    // 2: mode held 25000 cycles -> long press
    clear_stats();
    btn_raw[BTN_MODE] = 1'b1;
    run(25000);
    chk("t2_press_cyc", p_cyc[BTN_MODE], 202);
    chk("t2_long_cyc", l_cyc[BTN_MODE], 20201);
    chk("t2_long_cnt", l_cnt[BTN_MODE], 1);
    chk("t2_no_rel", r_cnt[BTN_MODE], 0);
    clear_stats();
    btn_raw[BTN_MODE] = 1'b0;
    run(400);
    chk("t2_rel_cyc", r_cyc[BTN_MODE], 202);
    chk("t2_rel_long", l_cnt[BTN_MODE], 0);
    chk("t2_level_off", btn_level, 4'h0);

    // 3: stop bouncing with 50-cycle bursts never commits
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      btn_raw[BTN_STOP] = 1'b1; run(50);
      btn_raw[BTN_STOP] = 1'b0; run(50);
    end
    run(300);
    chk("t3_no_press", p_cnt[BTN_STOP], 0);
    chk("t3_no_rel", r_cnt[BTN_STOP], 0);
    chk("t3_no_level", lvl_seen[BTN_STOP], 1'b0);

    // 4: start short press, then a press with a 30-cycle glitch
    clear_stats();
    btn_raw[BTN_START] = 1'b1; run(1000);
    btn_raw[BTN_START] = 1'b0; run(400);
    chk("t4_press_cyc", p_cyc[BTN_START], 202);
    chk("t4_rel_cyc", r_cyc[BTN_START], 1202);
    chk("t4_no_long", l_cnt[BTN_START], 0);
    clear_stats();
    btn_raw[BTN_START] = 1'b1; run(600);
    btn_raw[BTN_START] = 1'b0; run(30);
    btn_raw[BTN_START] = 1'b1; run(600);
    chk("t4_glitch_no_rel", r_cnt[BTN_START], 0);
    chk("t4_glitch_level", btn_level[BTN_START], 1'b1);
    chk("t4_glitch_press_cnt", p_cnt[BTN_START], 1);
    btn_raw[BTN_START] = 1'b0; run(400);
    chk("t4_glitch_rel_cyc", r_cyc[BTN_START], 1432);

    // 5: simultaneous start+stop, then reset mid-hold
    clear_stats();
    btn_raw = 4'b1100;
    run(300);
    chk("t5_press_cyc", first_press_t, 202);
    chk("t5_press_vec", first_press_vec, 4'b1100);
    chk("t5_level", btn_level, 4'b1100);
    reset_L = 1'b0;
    #1;
    chk("t5_rst_level", btn_level, 4'h0);
    chk("t5_rst_rel", btn_release, 4'h0);
    clear_stats();
    btn_raw = 4'h0;
    run(5);
    reset_L = 1'b1;
    run(400);
    chk("t5_post_rst_rel", r_cnt[2] + r_cnt[3], 0);
    chk("t5_post_rst_press", p_cnt[2] + p_cnt[3], 0);

    // 6: power held 8000 cycles past commit
    clear_stats();
    btn_raw[BTN_POWER] = 1'b1; run(8202);
    btn_raw[BTN_POWER] = 1'b0; run(400);
    chk("t6_press_cyc", p_cyc[BTN_POWER], 202);
    chk("t6_rel_cyc", r_cyc[BTN_POWER], 8404);
    chk("t6_no_long", l_cnt[BTN_POWER], 0);
    chk("t6_pp_excl", both_cnt, 0);
`ifdef AUTOREPEAT_EN
    chk("t6_rpt_cnt", rp_cnt[BTN_POWER], 4);
    chk("t6_rpt0", rp_cyc[BTN_POWER][0], 5201);
    chk("t6_rpt1", rp_cyc[BTN_POWER][1], 6201);
    chk("t6_rpt2", rp_cyc[BTN_POWER][2], 7201);
    chk("t6_rpt3", rp_cyc[BTN_POWER][3], 8201);
`else
    chk("t6_rpt_off", rp_cnt[0] + rp_cnt[1] + rp_cnt[2] + rp_cnt[3], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
